// File: rtl/gen_rr_arb_pkg.sv
`default_nettype none
// ============================================================================
// gen_rr_arb_pkg : shared types and helpers for the round-robin arbiter
// Rev 1.0
// ============================================================================
package gen_rr_arb_pkg;

   localparam int MAX_REQ = 32;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Lowest cyclic distance from 'start' wins; -1 when no candidate is set.
   function automatic int rr_first(input logic [MAX_REQ-1:0] cand,
                                   input int start, input int n);
      int k;
      rr_first = -1;
      for (int i = MAX_REQ - 1; i >= 0; i--) begin
         if (i < n) begin
            k = start + i;
            if (k >= n) k = k - n;
            if (cand[k[4:0]]) rr_first = k;
         end
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/gen_rr_arb_pick.sv
`default_nettype none
// ============================================================================
// gen_rr_arb_pick : combinational cyclic first-one finder (req, ptr, excl)
// Rev 1.0
// ============================================================================
module gen_rr_arb_pick
   import gen_rr_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IW    = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   input  logic [N_REQ-1:0] excl,
   output logic [N_REQ-1:0] onehot,
   output logic [IW-1:0]    idx,
   output logic             found
);

   logic [MAX_REQ-1:0] w_cand;
   int                 w_pos;

   always_comb begin
      w_cand              = '0;
      w_cand[N_REQ-1:0]   = req & ~excl;
      w_pos               = rr_first(w_cand, {{(32-IW){1'b0}}, ptr}, N_REQ);
      found               = (w_pos >= 0);
      onehot              = '0;
      idx                 = '0;
      if (w_pos >= 0) begin
         idx         = w_pos[IW-1:0];
         onehot[idx] = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/gen_rr_arb.sv
`default_nettype none
// ============================================================================
// gen_rr_arb : round-robin arbiter with per-grant quantum; optional lock
//              port enabled by GEN_RR_ARB_LOCK_EN.   Rev 1.0
// ============================================================================
module gen_rr_arb
   import gen_rr_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int QNT_W = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [QNT_W-1:0]          qnt_lim,
`ifdef GEN_RR_ARB_LOCK_EN
   input  logic [N_REQ-1:0]          lock,
`endif
   output logic [N_REQ-1:0]          gnt,
   output logic                      gnt_vld,
   output logic [idx_w(N_REQ)-1:0]   gnt_idx,
   output logic [QNT_W-1:0]          qnt_cnt
);

   localparam int IW = idx_w(N_REQ);

   state_t             r_state, w_nxt_state;
   logic [N_REQ-1:0]   r_gnt, w_nxt_gnt;
   logic [IW-1:0]      r_idx, w_nxt_idx;
   logic [IW-1:0]      r_ptr, w_nxt_ptr;
   logic [QNT_W-1:0]   r_cnt, w_nxt_cnt;
   logic [QNT_W-1:0]   r_lim, w_nxt_lim;

   logic               w_hold;
   logic               w_drop;
   logic               w_at_lim;
   logic               w_release;
   logic [IW-1:0]      w_ptr_inc;
   logic [IW-1:0]      w_pick_ptr;
   logic [N_REQ-1:0]   w_pick_excl;
   logic [N_REQ-1:0]   w_onehot;
   logic [IW-1:0]      w_pidx;
   logic               w_found;

`ifdef GEN_RR_ARB_LOCK_EN
   assign w_hold = lock[r_idx];
`else
   assign w_hold = 1'b0;
`endif

   assign w_drop      = ~req[r_idx];
   assign w_at_lim    = (r_cnt == r_lim);
   assign w_release   = w_drop | (w_at_lim & ~w_hold);
   assign w_ptr_inc   = (r_idx == IW'(N_REQ - 1)) ? '0 : r_idx + IW'(1);

   // In GRANT the search restarts just past the owner; the owner is masked only when it dropped.
   assign w_pick_ptr  = (r_state == GRANT) ? w_ptr_inc : r_ptr;
   assign w_pick_excl = ((r_state == GRANT) && w_drop) ? r_gnt : '0;

   gen_rr_arb_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_pick (
      .req    (req),
      .ptr    (w_pick_ptr),
      .excl   (w_pick_excl),
      .onehot (w_onehot),
      .idx    (w_pidx),
      .found  (w_found)
   );

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_gnt   = r_gnt;
      w_nxt_idx   = r_idx;
      w_nxt_ptr   = r_ptr;
      w_nxt_cnt   = r_cnt;
      w_nxt_lim   = r_lim;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_nxt_state = GRANT;
               w_nxt_gnt   = w_onehot;
               w_nxt_idx   = w_pidx;
               w_nxt_cnt   = '0;
               w_nxt_lim   = qnt_lim;
            end
         end
         GRANT: begin
            if (w_release) begin
               w_nxt_ptr = w_ptr_inc;
               if (w_found) begin
                  w_nxt_gnt = w_onehot;
                  w_nxt_idx = w_pidx;
                  w_nxt_cnt = '0;
                  w_nxt_lim = qnt_lim;
               end else begin
                  w_nxt_state = IDLE;
                  w_nxt_gnt   = '0;
                  w_nxt_cnt   = '0;
               end
            end else if (!w_at_lim) begin
               w_nxt_cnt = r_cnt + QNT_W'(1);
            end
         end
         default: begin
            w_nxt_state = IDLE;
            w_nxt_gnt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_idx   <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
         r_lim   <= '0;
      end else begin
         r_state <= w_nxt_state;
         r_gnt   <= w_nxt_gnt;
         r_idx   <= w_nxt_idx;
         r_ptr   <= w_nxt_ptr;
         r_cnt   <= w_nxt_cnt;
         r_lim   <= w_nxt_lim;
      end
   end

   assign gnt     = r_gnt;
   assign gnt_vld = |r_gnt;
   assign gnt_idx = r_idx;
   assign qnt_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gen_rr_arb.sv
`default_nettype none
// ============================================================================
// tb_gen_rr_arb : randomized scoreboard bench for gen_rr_arb (N_REQ=4, QNT_W=4)
// Rev 1.0
// ============================================================================
module tb_gen_rr_arb;

   localparam int N  = 4;
   localparam int QW = 4;

   typedef struct packed {
      logic [N-1:0]  gnt;
      logic          vld;
      logic [1:0]    idx;
      logic [QW-1:0] cnt;
   } exp_t;

   logic          clk;
   logic          rst;
   logic [N-1:0]  req;
   logic [QW-1:0] qnt_lim;
   logic [N-1:0]  lock_s;
   logic [N-1:0]  gnt;
   logic          gnt_vld;
   logic [1:0]    gnt_idx;
   logic [QW-1:0] qnt_cnt;

   gen_rr_arb #(.N_REQ(N), .QNT_W(QW)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .qnt_lim (qnt_lim),
`ifdef GEN_RR_ARB_LOCK_EN
      .lock    (lock_s),
`endif
      .gnt     (gnt),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx),
      .qnt_cnt (qnt_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb_q[$];

   // Reference model: owner as an integer (-1 = nobody), counter and pointer as plain ints.
   int m_own  = -1;
   int m_cnt  = 0;
   int m_lim  = 0;
   int m_ptr  = 0;
   int m_last = 0;

   function automatic int m_pick(input logic [N-1:0] r, input int start);
      logic [31:0] rr;
      int          k;
      rr = 32'(r);
      for (int off = 0; off < N; off++) begin
         k = (start + off) % N;
         if (rr[k[4:0]]) return k;
      end
      return -1;
   endfunction

   task automatic m_reset();
      m_own = -1; m_cnt = 0; m_lim = 0; m_ptr = 0; m_last = 0;
   endtask

   task automatic m_take(input int p, input int lim);
      m_own = p; m_last = p; m_cnt = 0; m_lim = lim;
   endtask

   task automatic m_step(input logic [N-1:0] r, input int lim, input logic [N-1:0] lk);
      logic [31:0] rr;
      logic [31:0] lr;
      bit          drop;
      bit          expire;
      int          p;
      rr = 32'(r);
      lr = 32'(lk);
`ifndef GEN_RR_ARB_LOCK_EN
      lr = '0;
`endif
      if (m_own < 0) begin
         p = m_pick(r, m_ptr);
         if (p >= 0) m_take(p, lim);
      end else begin
         drop   = !rr[m_own[4:0]];
         expire = (m_cnt == m_lim) && !lr[m_own[4:0]];
         if (drop || expire) begin
            m_ptr = (m_own + 1) % N;
            p = m_pick(r, m_ptr);
            if (p >= 0) m_take(p, lim);
            else begin
               m_own = -1;
               m_cnt = 0;
            end
         end else if (m_cnt < m_lim) begin
            m_cnt++;
         end
      end
   endtask

   function automatic exp_t m_out();
      exp_t e;
      e.gnt = (m_own >= 0) ? N'(1 << m_own) : '0;
      e.vld = (m_own >= 0);
      e.idx = 2'(m_last);
      e.cnt = QW'(m_cnt);
      return e;
   endfunction

   // One stimulus cycle: drive at negedge, predict the state after the next posedge.
   task automatic cyc(input logic r_rst, input logic [N-1:0] r, input int lim,
                      input logic [N-1:0] lk);
      @(negedge clk);
      rst     = r_rst;
      req     = r;
      qnt_lim = QW'(lim);
      lock_s  = lk;
      if (r_rst) m_reset();
      else       m_step(r, lim, lk);
      sb_q.push_back(m_out());
   endtask

   task automatic mid_reset();
      @(negedge clk);
      #3;
      rst = 1'b1;
      #1;
      n_vec++;
      if (gnt !== '0 || gnt_vld !== 1'b0) begin
         n_err++;
         $display("FAIL async_rst: gnt=%b vld=%b, want gnt=0000 vld=0", gnt, gnt_vld);
      end
      m_reset();
      sb_q.push_back(m_out());
   endtask

   // Monitor: every cycle the DUT presents a state, compare against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (gnt !== e.gnt || gnt_vld !== e.vld || qnt_cnt !== e.cnt ||
                (e.vld && gnt_idx !== e.idx) || (!e.vld && gnt_idx !== e.idx)) begin
               n_err++;
               $display("FAIL grant @%0t: gnt=%b vld=%b idx=%0d cnt=%0d, want gnt=%b vld=%b idx=%0d cnt=%0d",
                        $time, gnt, gnt_vld, gnt_idx, qnt_cnt, e.gnt, e.vld, e.idx, e.cnt);
            end
         end
      end
   end

   initial begin
      logic [N-1:0] nr;
      logic [N-1:0] lk;
      int           lim;
      rst = 1'b1; req = '0; qnt_lim = '0; lock_s = '0;

      repeat (2) cyc(1'b1, 4'b0000, 0, 4'b0000);

      // single requester, wrap at limit
      repeat (10) cyc(1'b0, 4'b0001, 3, 4'b0000);
      repeat (2)  cyc(1'b0, 4'b0000, 3, 4'b0000);
      // all requesting, two-cycle quantum
      repeat (12) cyc(1'b0, 4'b1111, 1, 4'b0000);
      // one-cycle quantum, two requesters
      repeat (8)  cyc(1'b0, 4'b0101, 0, 4'b0000);

      // reset mid-grant, then idle
      repeat (3)  cyc(1'b0, 4'b1111, 5, 4'b0000);
      mid_reset();
      repeat (3)  cyc(1'b0, 4'b0000, 5, 4'b0000);

      // owner 1 drops at qnt_cnt=1 while requester 3 waits
      cyc(1'b1, 4'b0000, 0, 4'b0000);
      repeat (2)  cyc(1'b0, 4'b1010, 7, 4'b0000);
      repeat (3)  cyc(1'b0, 4'b1000, 7, 4'b0000);

      // limit change mid-grant only affects the next grant
      repeat (3)  cyc(1'b0, 4'b0011, 4, 4'b0000);
      repeat (6)  cyc(1'b0, 4'b0011, 0, 4'b0000);

`ifdef GEN_RR_ARB_LOCK_EN
      cyc(1'b1, 4'b0000, 0, 4'b0000);
      repeat (6)  cyc(1'b0, 4'b0011, 2, 4'b0001);
      repeat (4)  cyc(1'b0, 4'b0011, 2, 4'b0000);
`endif

      nr = '0;
      for (int c = 0; c < 600; c++) begin
         nr = nr | (N'($urandom) & N'($urandom));
         if (m_own >= 0 && $urandom_range(0, 3) == 0) nr = nr & ~N'(1 << m_own);
         lim = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
         lk  = N'($urandom) & N'($urandom);
         if ($urandom_range(0, 99) == 0) begin
            nr = '0;
            cyc(1'b1, nr, lim, lk);
         end else begin
            cyc(1'b0, nr, lim, lk);
         end
      end

      @(posedge clk);
      #2;
      n_vec++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d predictions left, want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
